ddr3_cmd_responder: RTL and testbench
=====================================

Name: ddr3_cmd_responder

Overview:
- DRAM-side command decoder and bank-state tracker; the responder end of the controller command bus driven by the DDR3 bench interface.
- Samples the CKE/CS#/RAS#/CAS#/WE#/BA/ADDR pins on rising ck and decodes each command.
- Maintains mode registers MR0–MR3, per-bank open/closed state, refresh and ZQ activity, and flags protocol/timing violations.
- Used as a bench-side protocol checker and as the command front end of a synthesizable DRAM model.

Parameters:
- BA_BITS, 3, bank address width (8 banks).
- ADDR_BITS, 14, address bus width.
- TMRD, 4, min cycles from MRS to any non-NOP command.
- TRCD, 6, min cycles from ACT to RD/WR on the same bank.
- TRP, 6, min cycles from PRE to ACT on the same bank.
- TRFC, 44, cycles the device is busy after REF.
- TZQCL, 256, ZQ long busy cycles.
- TZQCS, 64, ZQ short busy cycles.

Ports:
- ck, input, 1, clock; all logic on posedge.
- rst_n, input, 1, synchronous active-low reset.
- cke, cs_n, ras_n, cas_n, we_n: input, 1 each, command pins.
- ba, input, BA_BITS, bank address.
- addr, input, ADDR_BITS, address; addr[10] = AP/all/long.
- cmd_valid, output, 1, decoded non-NOP command this cycle.
- cmd_code, output, 3, {ras_n,cas_n,we_n} of the accepted command.
- cmd_ba, output, BA_BITS, registered ba.
- cmd_addr, output, ADDR_BITS, registered addr.
- mr0, mr1, mr2, mr3: output, ADDR_BITS each, mode registers.
- bank_open, output, 2**BA_BITS, one bit per bank.
- busy, output, 1, REF or ZQ in progress.
- ref_count, output, 16, count of accepted REF commands.
- viol, output, 1, one-cycle violation pulse.
- viol_code, output, 3, violation cause; valid with viol.

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0, all banks closed, all timers 0, MRs 0.
- Sampling: command is valid when cke=1 and cs_n=0. Decode {ras_n,cas_n,we_n}:
  - 000 MRS, 001 REF, 010 PRE, 011 ACT, 100 WR, 101 RD, 110 ZQ, 111 NOP.
  - cs_n=1 is DESELECT, treated as NOP. cke=0: pins ignored, timers still count.
- Latency: all outputs registered; cmd_* and viol appear one cycle after the sampling edge. cmd_valid=1 for a single cycle per non-NOP command.
- Timers: one tRCD and one tRP down-counter per bank, plus global tMRD and busy counters. All saturate at 0; loaded on the accepting edge with PARAM-1.
- MRS: mr[ba[1:0]] <= addr; loads tMRD. ba[2] ignored.
- ACT: sets bank_open[ba]; loads tRCD[ba].
- PRE: addr[10]=1 closes all banks and loads every tRP; else closes bank ba and loads tRP[ba].
  - PRE to an already-closed bank is legal, but tRP is still reloaded.
- RD/WR: bank must be open. addr[10]=1 (auto-precharge) closes the bank and loads tRP[ba] after the command.
- REF: increments ref_count (wraps 0xFFFF->0); busy for TRFC.
- ZQ: busy for TZQCL if addr[10]=1, else TZQCS.
- Violation codes, highest priority first; only one is reported per cycle:
  - 1 = command while busy.
  - 2 = command before tMRD expires.
  - 3 = REF with any bank open.
  - 4 = ACT to open bank.
  - 5 = ACT before tRP[ba]=0.
  - 6 = RD/WR to closed bank.
  - 7 = RD/WR before tRCD[ba]=0.
- A violating command is still reported on cmd_* and still updates state, except:
  - 4 does not reload tRCD.
  - 6 does not change bank state.
- Simultaneous events: a timer reload on the same edge as its expiry takes the reload value. Reset mid-timer clears everything on that edge.

Optional Feature:
- DDR3_ROW_TRACK_EN: when defined, a per-bank row register captures addr on ACT, and two extra outputs are added:
  - open_row, ADDR_BITS, row of cmd_ba.
  - row_valid, 1, bank_open[cmd_ba].
- On PRE, the row register is not cleared; row_valid goes 0.
- When undefined, the ports and registers are absent and all other behaviour is unchanged.

Test Plan:
- Reset, then MRS ba=0 addr=0x1D70 followed by MRS ba=2 addr=0x0008 with 4 NOPs between -> mr0=0x1D70, mr2=0x0008, viol never asserted.
- ACT ba=3 row=0x0123, RD ba=3 after 2 cycles -> viol=1, code 7. RD after 6 cycles -> no viol; bank_open[3]=1.
- PRE addr[10]=1 with banks 1, 3, 5 open -> bank_open=0. ACT ba=1 three cycles later -> viol code 5.
- REF with bank 2 open -> code 3; then PRE all, wait TRP, REF -> ref_count+1, busy=1 for 44 cycles. NOP inside that window stays silent; ACT inside it -> code 1.
- ZQ addr[10]=1 -> busy=1 for exactly 256 cycles. Repeat with addr[10]=0 -> 64 cycles.
- Assert rst_n=0 for one cycle during tRCD countdown -> bank_open=0, timers 0. RD immediately after -> code 6.

Source files
------------

// File: rtl/ddr3_cmd_responder.sv
// DDR3 command decoder and bank-state tracker: decodes pin-level commands, keeps mode registers,
// bank state and timers, and flags protocol violations. Define DDR3_ROW_TRACK_EN to add row tracking.
module ddr3_cmd_responder #(
  parameter int unsigned BA_BITS   = 3,
  parameter int unsigned ADDR_BITS = 14,
  parameter int unsigned TMRD      = 4,
  parameter int unsigned TRCD      = 6,
  parameter int unsigned TRP       = 6,
  parameter int unsigned TRFC      = 44,
  parameter int unsigned TZQCL     = 256,
  parameter int unsigned TZQCS     = 64
) (
  input  logic                    ck,
  input  logic                    rst_n,
  input  logic                    cke,
  input  logic                    cs_n,
  input  logic                    ras_n,
  input  logic                    cas_n,
  input  logic                    we_n,
  input  logic [BA_BITS-1:0]      ba,
  input  logic [ADDR_BITS-1:0]    addr,
  output logic                    cmd_valid,
  output logic [2:0]              cmd_code,
  output logic [BA_BITS-1:0]      cmd_ba,
  output logic [ADDR_BITS-1:0]    cmd_addr,
  output logic [ADDR_BITS-1:0]    mr0,
  output logic [ADDR_BITS-1:0]    mr1,
  output logic [ADDR_BITS-1:0]    mr2,
  output logic [ADDR_BITS-1:0]    mr3,
  output logic [2**BA_BITS-1:0]   bank_open,
  output logic                    busy,
  output logic [15:0]             ref_count,
  output logic                    viol,
  output logic [2:0]              viol_code
`ifdef DDR3_ROW_TRACK_EN
  ,
  output logic [ADDR_BITS-1:0]    open_row,
  output logic                    row_valid
`endif
);

  localparam int unsigned NBanks  = 2 ** BA_BITS;
  localparam int unsigned TimMax  = (TMRD > TRCD) ? ((TMRD > TRP) ? TMRD : TRP)
                                                  : ((TRCD > TRP) ? TRCD : TRP);
  localparam int unsigned TimW    = $clog2(TimMax + 1);
  localparam int unsigned BusyMax = (TRFC > TZQCL) ? ((TRFC > TZQCS) ? TRFC : TZQCS)
                                                   : ((TZQCL > TZQCS) ? TZQCL : TZQCS);
  localparam int unsigned BusyW   = $clog2(BusyMax + 1);

  localparam logic [2:0] CmdMrs = 3'b000;
  localparam logic [2:0] CmdRef = 3'b001;
  localparam logic [2:0] CmdPre = 3'b010;
  localparam logic [2:0] CmdAct = 3'b011;
  localparam logic [2:0] CmdWr  = 3'b100;
  localparam logic [2:0] CmdRd  = 3'b101;
  localparam logic [2:0] CmdZq  = 3'b110;
  localparam logic [2:0] CmdNop = 3'b111;

  logic                 cmd_valid_q;
  logic [2:0]           cmd_code_q;
  logic [BA_BITS-1:0]   cmd_ba_q;
  logic [ADDR_BITS-1:0] cmd_addr_q;
  logic [ADDR_BITS-1:0] mr_q [4];
  logic [NBanks-1:0]    bank_open_q;
  logic [TimW-1:0]      trcd_q [NBanks];
  logic [TimW-1:0]      trp_q [NBanks];
  logic [TimW-1:0]      tmrd_q;
  logic [BusyW-1:0]     busy_cnt_q;
  logic                 busy_q;
  logic [15:0]          ref_count_q;
  logic                 viol_q;
  logic [2:0]           viol_code_q;
`ifdef DDR3_ROW_TRACK_EN
  logic [ADDR_BITS-1:0] row_q [NBanks];
`endif

  logic [2:0] code;
  logic       cmd_en;
  logic       is_ref;
  logic       is_act;
  logic       is_rw;
  logic       ba_open;
  logic [2:0] vcode;

  assign code    = {ras_n, cas_n, we_n};
  assign cmd_en  = cke && !cs_n && (code != CmdNop);
  assign is_ref  = (code == CmdRef);
  assign is_act  = (code == CmdAct);
  assign is_rw   = (code == CmdRd) || (code == CmdWr);
  assign ba_open = bank_open_q[ba];

  // Priority encoder: only the highest-ranked violation is reported.
  always_comb begin
    vcode = 3'd0;
    if (cmd_en) begin
      if (busy_q)                                vcode = 3'd1;
      else if (tmrd_q != '0)                     vcode = 3'd2;
      else if (is_ref && (bank_open_q != '0))    vcode = 3'd3;
      else if (is_act && ba_open)                vcode = 3'd4;
      else if (is_act && (trp_q[ba] != '0))      vcode = 3'd5;
      else if (is_rw && !ba_open)                vcode = 3'd6;
      else if (is_rw && (trcd_q[ba] != '0))      vcode = 3'd7;
    end
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      cmd_ba_q    <= '0;
      cmd_addr_q  <= '0;
      for (int i = 0; i < 4; i++) mr_q[i] <= '0;
      bank_open_q <= '0;
      for (int i = 0; i < NBanks; i++) begin
        trcd_q[i] <= '0;
        trp_q[i]  <= '0;
`ifdef DDR3_ROW_TRACK_EN
        row_q[i]  <= '0;
`endif
      end
      tmrd_q      <= '0;
      busy_cnt_q  <= '0;
      busy_q      <= 1'b0;
      ref_count_q <= '0;
      viol_q      <= 1'b0;
      viol_code_q <= '0;
    end else begin
      // Free-running countdowns; loads below override on the same edge.
      if (tmrd_q != '0) tmrd_q <= tmrd_q - 1'b1;
      for (int i = 0; i < NBanks; i++) begin
        if (trcd_q[i] != '0) trcd_q[i] <= trcd_q[i] - 1'b1;
        if (trp_q[i] != '0)  trp_q[i]  <= trp_q[i] - 1'b1;
      end
      if (busy_cnt_q != '0) busy_cnt_q <= busy_cnt_q - 1'b1;
      // Lags the counter by one cycle so busy is high for the full busy length.
      busy_q <= (busy_cnt_q != '0);

      cmd_valid_q <= cmd_en;
      viol_q      <= (vcode != 3'd0);
      viol_code_q <= vcode;

      if (cmd_en) begin
        cmd_code_q <= code;
        cmd_ba_q   <= ba;
        cmd_addr_q <= addr;
        case (code)
          CmdMrs: begin
            mr_q[ba[1:0]] <= addr;
            tmrd_q        <= TimW'(TMRD - 1);
          end
          CmdRef: begin
            ref_count_q <= ref_count_q + 16'd1;
            busy_cnt_q  <= BusyW'(TRFC - 1);
            busy_q      <= 1'b1;
          end
          CmdPre: begin
            if (addr[10]) begin
              bank_open_q <= '0;
              for (int i = 0; i < NBanks; i++) trp_q[i] <= TimW'(TRP - 1);
            end else begin
              bank_open_q[ba] <= 1'b0;
              trp_q[ba]       <= TimW'(TRP - 1);
            end
          end
          CmdAct: begin
            bank_open_q[ba] <= 1'b1;
            if (vcode != 3'd4) trcd_q[ba] <= TimW'(TRCD - 1);
`ifdef DDR3_ROW_TRACK_EN
            row_q[ba] <= addr;
`endif
          end
          CmdWr, CmdRd: begin
            if ((vcode != 3'd6) && addr[10]) begin
              bank_open_q[ba] <= 1'b0;
              trp_q[ba]       <= TimW'(TRP - 1);
            end
          end
          CmdZq: begin
            busy_cnt_q <= addr[10] ? BusyW'(TZQCL - 1) : BusyW'(TZQCS - 1);
            busy_q     <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_ba    = cmd_ba_q;
  assign cmd_addr  = cmd_addr_q;
  assign mr0       = mr_q[0];
  assign mr1       = mr_q[1];
  assign mr2       = mr_q[2];
  assign mr3       = mr_q[3];
  assign bank_open = bank_open_q;
  assign busy      = busy_q;
  assign ref_count = ref_count_q;
  assign viol      = viol_q;
  assign viol_code = viol_code_q;
`ifdef DDR3_ROW_TRACK_EN
  assign open_row  = row_q[cmd_ba_q];
  assign row_valid = bank_open_q[cmd_ba_q];
`endif

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Directed self-checking bench for ddr3_cmd_responder (default build, row tracking off).
module tb_ddr3_cmd_responder;

  localparam logic [2:0] Mrs = 3'b000;
  localparam logic [2:0] Ref = 3'b001;
  localparam logic [2:0] Pre = 3'b010;
  localparam logic [2:0] Act = 3'b011;
  localparam logic [2:0] Rd  = 3'b101;
  localparam logic [2:0] Zq  = 3'b110;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic        cke = 1'b1;
  logic        cs_n = 1'b1;
  logic        ras_n = 1'b1;
  logic        cas_n = 1'b1;
  logic        we_n = 1'b1;
  logic [2:0]  ba = '0;
  logic [13:0] addr = '0;

  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [2:0]  cmd_ba;
  logic [13:0] cmd_addr;
  logic [13:0] mr0, mr1, mr2, mr3;
  logic [7:0]  bank_open;
  logic        busy;
  logic [15:0] ref_count;
  logic        viol;
  logic [2:0]  viol_code;

  int n_tests = 0;
  int n_fail = 0;
  int n_busy;

  always #5 ck = ~ck;

  ddr3_cmd_responder dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .cke       (cke),
    .cs_n      (cs_n),
    .ras_n     (ras_n),
    .cas_n     (cas_n),
    .we_n      (we_n),
    .ba        (ba),
    .addr      (addr),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_ba    (cmd_ba),
    .cmd_addr  (cmd_addr),
    .mr0       (mr0),
    .mr1       (mr1),
    .mr2       (mr2),
    .mr3       (mr3),
    .bank_open (bank_open),
    .busy      (busy),
    .ref_count (ref_count),
    .viol      (viol),
    .viol_code (viol_code)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one command for one sampling edge, then return the pins to NOP.
  task automatic issue(input logic [2:0] code, input logic [2:0] b, input logic [13:0] a);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = code;
    ba = b;
    addr = a;
    @(posedge ck);
    #1;
    cs_n = 1'b1;
    {ras_n, cas_n, we_n} = 3'b111;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge ck);
      #1;
    end
  endtask

  // Counts cycles with busy high from now on; bounded so a stuck busy still ends.
  task automatic measure_busy(output int cnt);
    cnt = 0;
    for (int g = 0; (g < 400) && busy; g++) begin
      cnt++;
      @(posedge ck);
      #1;
    end
  endtask

  initial begin
    // Reset
    idle(2);
    check_eq("rst cmd_valid", 32'(cmd_valid), 32'd0);
    check_eq("rst bank_open", 32'(bank_open), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst ref_count", 32'(ref_count), 32'd0);
    check_eq("rst viol", 32'(viol), 32'd0);
    check_eq("rst mr0", 32'(mr0), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Mode registers and tMRD
    issue(Mrs, 3'd0, 14'h1D70);
    check_eq("mrs0 cmd_valid", 32'(cmd_valid), 32'd1);
    check_eq("mrs0 cmd_code", 32'(cmd_code), 32'd0);
    check_eq("mrs0 viol", 32'(viol), 32'd0);
    idle(1);
    check_eq("nop cmd_valid", 32'(cmd_valid), 32'd0);
    idle(3);
    issue(Mrs, 3'd2, 14'h0008);
    check_eq("mrs2 viol", 32'(viol), 32'd0);
    check_eq("mr0", 32'(mr0), 32'h1D70);
    check_eq("mr2", 32'(mr2), 32'h0008);
    idle(2);
    issue(Mrs, 3'd1, 14'h0044);
    check_eq("tmrd early viol", 32'(viol), 32'd1);
    check_eq("tmrd early code", 32'(viol_code), 32'd2);
    check_eq("mr1 still written", 32'(mr1), 32'h0044);
    idle(3);
    issue(Mrs, 3'd7, 14'h0155);
    check_eq("tmrd exact viol", 32'(viol), 32'd0);
    check_eq("mr3 via ba[1:0]", 32'(mr3), 32'h0155);
    idle(4);

    // ACT then RD against tRCD
    issue(Act, 3'd3, 14'h0123);
    check_eq("act3 viol", 32'(viol), 32'd0);
    check_eq("act3 bank_open", 32'(bank_open), 32'h08);
    idle(1);
    issue(Rd, 3'd3, 14'h0000);
    check_eq("trcd early code", 32'(viol_code), 32'd7);
    check_eq("trcd early viol", 32'(viol), 32'd1);
    idle(3);
    issue(Rd, 3'd3, 14'h0010);
    check_eq("trcd exact viol", 32'(viol), 32'd0);
    check_eq("rd cmd_code", 32'(cmd_code), 32'h5);
    check_eq("rd cmd_ba", 32'(cmd_ba), 32'd3);
    check_eq("rd cmd_addr", 32'(cmd_addr), 32'h0010);
    check_eq("rd bank3 open", 32'(bank_open[3]), 32'd1);

    // Precharge all, then tRP and ACT-to-open-bank
    issue(Act, 3'd1, 14'h0001);
    issue(Act, 3'd5, 14'h0005);
    check_eq("banks 1 3 5", 32'(bank_open), 32'h2A);
    issue(Pre, 3'd0, 14'h0400);
    check_eq("pre all", 32'(bank_open), 32'h00);
    check_eq("pre all viol", 32'(viol), 32'd0);
    idle(2);
    issue(Act, 3'd1, 14'h0002);
    check_eq("trp early code", 32'(viol_code), 32'd5);
    check_eq("trp early opens", 32'(bank_open), 32'h02);
    issue(Act, 3'd1, 14'h0003);
    check_eq("act open code", 32'(viol_code), 32'd4);
    idle(1);
    issue(Act, 3'd2, 14'h0004);
    check_eq("trp exact viol", 32'(viol), 32'd0);

    // REF with banks open still counts and goes busy
    issue(Ref, 3'd0, 14'h0000);
    check_eq("ref open code", 32'(viol_code), 32'd3);
    check_eq("ref open count", 32'(ref_count), 32'd1);
    check_eq("ref open busy", 32'(busy), 32'd1);
    idle(44);
    check_eq("ref busy ends", 32'(busy), 32'd0);
    issue(Pre, 3'd0, 14'h0400);
    check_eq("pre all 2 viol", 32'(viol), 32'd0);
    idle(5);
    issue(Ref, 3'd0, 14'h0000);
    check_eq("ref viol", 32'(viol), 32'd0);
    check_eq("ref count", 32'(ref_count), 32'd2);
    idle(4);
    check_eq("busy nop valid", 32'(cmd_valid), 32'd0);
    check_eq("busy nop viol", 32'(viol), 32'd0);
    check_eq("busy mid", 32'(busy), 32'd1);
    issue(Act, 3'd0, 14'h0000);
    check_eq("act busy code", 32'(viol_code), 32'd1);
    measure_busy(n_busy);
    check_eq("trfc remaining", 32'(n_busy), 32'd39);

    // ZQ long and short
    issue(Zq, 3'd0, 14'h0400);
    check_eq("zql viol", 32'(viol), 32'd0);
    measure_busy(n_busy);
    check_eq("zqcl length", 32'(n_busy), 32'd256);
    issue(Zq, 3'd0, 14'h0000);
    measure_busy(n_busy);
    check_eq("zqcs length", 32'(n_busy), 32'd64);

    // Reset during tRCD countdown
    issue(Act, 3'd6, 14'h0066);
    check_eq("act6 bank_open", 32'(bank_open), 32'h41);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check_eq("mid rst bank_open", 32'(bank_open), 32'd0);
    check_eq("mid rst ref_count", 32'(ref_count), 32'd0);
    check_eq("mid rst mr0", 32'(mr0), 32'd0);
    issue(Rd, 3'd6, 14'h0000);
    check_eq("rd closed code", 32'(viol_code), 32'd6);
    check_eq("rd closed bank", 32'(bank_open), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
